// File: rtl/key_pkg.sv
// key_pkg: PS/2 scan-code constants, key values, parser states and make-code map.
package key_pkg;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_0     = 8'h45;
    localparam logic [7:0] SC_1     = 8'h16;
    localparam logic [7:0] SC_2     = 8'h1E;
    localparam logic [7:0] SC_3     = 8'h26;
    localparam logic [7:0] SC_4     = 8'h25;
    localparam logic [7:0] SC_5     = 8'h2E;
    localparam logic [7:0] SC_6     = 8'h36;
    localparam logic [7:0] SC_7     = 8'h3D;
    localparam logic [7:0] SC_8     = 8'h3E;
    localparam logic [7:0] SC_9     = 8'h46;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_TAB   = 8'h0D;

    localparam logic [3:0] KEY_BKSP  = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;
    localparam logic [3:0] KEY_TAB   = 4'hC;
    localparam logic [3:0] KEY_NONE  = 4'hF;

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} parse_state_t;

    // Returns {hit, value}; value is KEY_NONE on a miss.
    function automatic logic [4:0] map_make(input logic [7:0] sc);
        case (sc)
            SC_0:     return {1'b1, 4'h0};
            SC_1:     return {1'b1, 4'h1};
            SC_2:     return {1'b1, 4'h2};
            SC_3:     return {1'b1, 4'h3};
            SC_4:     return {1'b1, 4'h4};
            SC_5:     return {1'b1, 4'h5};
            SC_6:     return {1'b1, 4'h6};
            SC_7:     return {1'b1, 4'h7};
            SC_8:     return {1'b1, 4'h8};
            SC_9:     return {1'b1, 4'h9};
            SC_BKSP:  return {1'b1, KEY_BKSP};
            SC_ENTER: return {1'b1, KEY_ENTER};
            SC_TAB:   return {1'b1, KEY_TAB};
            default:  return {1'b0, KEY_NONE};
        endcase
    endfunction
endpackage

// File: rtl/key_event_fifo_if.sv
// key_event_fifo_if: byte-in / key-out bus.
//   master drives rx_byte, rx_valid, rd_en, ovf_clr; slave drives key_code, key_valid, fifo_count, overflow.
interface key_event_fifo_if #(parameter int DEPTH = 4);
    logic [7:0]             rx_byte;
    logic                   rx_valid;
    logic                   rd_en;
    logic                   ovf_clr;
    logic [3:0]             key_code;
    logic                   key_valid;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   overflow;
    modport master(output rx_byte, rx_valid, rd_en, ovf_clr, input key_code, key_valid, fifo_count, overflow);
    modport slave(input rx_byte, rx_valid, rd_en, ovf_clr, output key_code, key_valid, fifo_count, overflow);
endinterface

// File: rtl/key_sync_fifo.sv
// key_sync_fifo: DEPTH x W synchronous FIFO.
//   ports: clk, rst, push, pop, din -> dout (head), count, drop (push refused because full without pop).
module key_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [AW:0]  count,
    output logic         drop
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;
    assign do_pop  = pop && count != '0;
    // a pop frees the slot the push needs, so a full FIFO can still accept
    assign do_push = push && (count != (AW+1)'(DEPTH) || do_pop);
    assign drop    = push && !do_push;
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/key_event_fifo.sv
// key_event_fifo: PS/2 scan-code parser that queues mapped key presses.
//   ports: clk, rst, bus (slave: rx_byte/rx_valid/rd_en/ovf_clr in; key_code/key_valid/fifo_count/overflow out).
//   KEY_REPEAT_FILTER_EN: drop typematic repeats of the last pushed make until its break arrives.
module key_event_fifo
    import key_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    key_event_fifo_if.slave  bus
);
    parse_state_t state, state_nx;
    logic [4:0]   mk;
    logic         make_req, push, drop;
    logic [3:0]   head;
    assign mk = map_make(bus.rx_byte);
    always_comb begin
        state_nx = state;
        make_req = 1'b0;
        if (bus.rx_valid)
            case (state)
                IDLE: begin
                    state_nx = bus.rx_byte == SC_BREAK ? BRK : bus.rx_byte == SC_EXT ? EXT : IDLE;
                    make_req = mk[4];
                end
                BRK:     state_nx = IDLE;
                EXT: begin
                    state_nx = bus.rx_byte == SC_BREAK ? EXT_BRK : IDLE;
                    make_req = bus.rx_byte == SC_ENTER;
                end
                EXT_BRK: state_nx = IDLE;
            endcase
    end
`ifdef KEY_REPEAT_FILTER_EN
    logic       last_v, brk;
    logic [3:0] last;
    // E0 5A maps to the same value as plain 5A, so mk covers both break forms
    assign brk  = bus.rx_valid && ((state == BRK && mk[4]) || (state == EXT_BRK && bus.rx_byte == SC_ENTER));
    assign push = make_req && !(last_v && last == mk[3:0]);
    always_ff @(posedge clk) begin
        if (rst) begin
            last_v <= 1'b0;
            last   <= KEY_NONE;
        end else if (push) begin
            last_v <= 1'b1;
            last   <= mk[3:0];
        end else if (brk && last == mk[3:0]) begin
            last_v <= 1'b0;
        end
    end
`else
    assign push = make_req;
`endif
    key_sync_fifo #(.DEPTH(DEPTH), .W(4)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (bus.rd_en),
        .din   (mk[3:0]),
        .dout  (head),
        .count (bus.fifo_count),
        .drop  (drop)
    );
    assign bus.key_valid = bus.fifo_count != '0;
    assign bus.key_code  = bus.key_valid ? head : KEY_NONE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bus.overflow <= 1'b0;
        end else begin
            state        <= state_nx;
            // a fresh drop outranks a clear in the same cycle
            bus.overflow <= drop ? 1'b1 : bus.ovf_clr ? 1'b0 : bus.overflow;
        end
    end
endmodule

// File: tb/tb_key_event_fifo.sv
// tb_key_event_fifo: table-driven and sequence checks of key_event_fifo with a scoreboard queue.
module tb_key_event_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [3:0] sb[$];

    key_event_fifo_if #(.DEPTH(4)) bus();
    key_event_fifo #(.DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] b;
        logic       hit;
        logic [3:0] v;
    } vec_t;
    vec_t vt[19];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", n, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic rd = 1'b0, input logic clr = 1'b0);
        bus.rx_byte  = b;
        bus.rx_valid = 1'b1;
        bus.rd_en    = rd;
        bus.ovf_clr  = clr;
        tick();
        bus.rx_valid = 1'b0;
        bus.rd_en    = 1'b0;
        bus.ovf_clr  = 1'b0;
    endtask

    task automatic drain(input string n);
        int k;
        for (k = 0; k < 20 && bus.key_valid; k++) begin
            if (sb.size() == 0) chk({n, "_extra"}, {28'd0, bus.key_code}, 32'hDEAD);
            else chk({n, "_code"}, {28'd0, bus.key_code}, {28'd0, sb.pop_front()});
            bus.rd_en = 1'b1;
            tick();
            bus.rd_en = 1'b0;
        end
        if (k == 20) chk({n, "_drain_bound"}, 32'd1, 32'd0);
        chk({n, "_left"}, sb.size(), 0);
        chk({n, "_empty_code"}, {28'd0, bus.key_code}, 32'hF);
    endtask

    initial begin
        vt = '{'{8'h45,1,4'h0}, '{8'h16,1,4'h1}, '{8'h1E,1,4'h2}, '{8'h26,1,4'h3},
               '{8'h25,1,4'h4}, '{8'h2E,1,4'h5}, '{8'h36,1,4'h6}, '{8'h3D,1,4'h7},
               '{8'h3E,1,4'h8}, '{8'h46,1,4'h9}, '{8'h66,1,4'hA}, '{8'h5A,1,4'hB},
               '{8'h0D,1,4'hC}, '{8'hAA,0,4'hF}, '{8'hFA,0,4'hF}, '{8'hEE,0,4'hF},
               '{8'hFE,0,4'hF}, '{8'h00,0,4'hF}, '{8'h76,0,4'hF}};
        bus.rx_byte = 8'h00; bus.rx_valid = 1'b0; bus.rd_en = 1'b0; bus.ovf_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_valid", {31'd0, bus.key_valid}, 0);
        chk("rst_code", {28'd0, bus.key_code}, 32'hF);
        chk("rst_count", {29'd0, bus.fifo_count}, 0);
        chk("rst_ovf", {31'd0, bus.overflow}, 0);

        foreach (vt[i]) begin
            send(vt[i].b);
            if (vt[i].hit) sb.push_back(vt[i].v);
            chk($sformatf("map_%02h_count", vt[i].b), {29'd0, bus.fifo_count}, sb.size());
            send(8'hF0);
            send(vt[i].b);
            chk($sformatf("map_%02h_rel", vt[i].b), {29'd0, bus.fifo_count}, sb.size());
            drain($sformatf("map_%02h", vt[i].b));
        end

        bus.rd_en = 1'b1; tick(); bus.rd_en = 1'b0;
        chk("pop_empty_count", {29'd0, bus.fifo_count}, 0);

        send(8'h16);
        chk("r31_valid", {31'd0, bus.key_valid}, 1);
        send(8'hF0); send(8'h16);
        sb.push_back(4'h1);
        chk("r31_count", {29'd0, bus.fifo_count}, 1);
        drain("r31");
        chk("r31_valid_after", {31'd0, bus.key_valid}, 0);

        send(8'hE0); send(8'h5A);
        send(8'hE0); send(8'hF0); send(8'h5A);
        send(8'hE0); send(8'h75);
        sb.push_back(4'hB);
        chk("r32_count", {29'd0, bus.fifo_count}, 1);
        send(8'h45);
        sb.push_back(4'h0);
        chk("r32_idle", {29'd0, bus.fifo_count}, 2);
        drain("r32");

        send(8'h45, 1'b1);
        sb.push_back(4'h0);
        chk("push_pop_empty", {29'd0, bus.fifo_count}, 1);
        drain("pp_empty");

        send(8'h45); send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
        sb.push_back(4'h0); sb.push_back(4'h1); sb.push_back(4'h2); sb.push_back(4'h3);
        chk("r33_count", {29'd0, bus.fifo_count}, 4);
        chk("r33_ovf", {31'd0, bus.overflow}, 1);
        bus.ovf_clr = 1'b1; tick(); bus.ovf_clr = 1'b0;
        chk("r33_clr", {31'd0, bus.overflow}, 0);

        send(8'h2E, 1'b1);
        void'(sb.pop_front());
        sb.push_back(4'h5);
        chk("r34_count", {29'd0, bus.fifo_count}, 4);
        chk("r34_ovf", {31'd0, bus.overflow}, 0);
        chk("r34_head", {28'd0, bus.key_code}, 32'h1);
        drain("r34");

        send(8'h45); send(8'h16); send(8'h1E); send(8'h26);
        send(8'h25, 1'b0, 1'b1);
        sb.push_back(4'h0); sb.push_back(4'h1); sb.push_back(4'h2); sb.push_back(4'h3);
        chk("ovf_prio", {31'd0, bus.overflow}, 1);
        bus.ovf_clr = 1'b1; tick(); bus.ovf_clr = 1'b0;
        chk("ovf_prio_clr", {31'd0, bus.overflow}, 0);
        drain("ovf_prio");

        send(8'h1E); send(8'h1E); send(8'h1E); send(8'hF0); send(8'h1E); send(8'h1E);
`ifdef KEY_REPEAT_FILTER_EN
        repeat (2) sb.push_back(4'h2);
`else
        repeat (4) sb.push_back(4'h2);
`endif
        chk("r35_count", {29'd0, bus.fifo_count}, sb.size());
        send(8'h45); send(8'h16); send(8'h25); send(8'h26); send(8'h3D); send(8'h0D);
        chk("r36_pre_ovf", {31'd0, bus.overflow}, 1);
        send(8'hE0);
        rst = 1'b1;
        send(8'h45, 1'b1, 1'b0);
        rst = 1'b0;
        sb.delete();
        chk("r36_rst_count", {29'd0, bus.fifo_count}, 0);
        chk("r36_rst_ovf", {31'd0, bus.overflow}, 0);
        chk("r36_rst_code", {28'd0, bus.key_code}, 32'hF);
        send(8'h45);
        sb.push_back(4'h0);
        chk("r36_count", {29'd0, bus.fifo_count}, 1);
        chk("r36_ovf", {31'd0, bus.overflow}, 0);
        drain("r36");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/key_event_fifo.md
KEY_EVENT_FIFO -- requirements
Module: key_event_fifo

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entry count; power of two, 2..16.
REQ-002 clk  input  1  system clock; all logic rising-edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 rx_byte  input  8  scan-code byte from the PS/2 receiver.
REQ-005 rx_valid  input  1  one-cycle strobe; rx_byte valid this cycle.
REQ-006 rd_en  input  1  consumer pop request.
REQ-007 ovf_clr  input  1  clears sticky overflow.
REQ-008 key_code  output  4  head entry value; 4'hF when empty.
REQ-009 key_valid  output  1  FIFO non-empty.
REQ-010 fifo_count  output  $clog2(DEPTH)+1  occupied entries.
REQ-011 overflow  output  1  sticky; a press event was dropped because the FIFO was full.

Function
REQ-012 Parser FSM states: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0); advances only on rx_valid.
REQ-013 IDLE: F0->BRK; E0->EXT; mapped make code->push, stay IDLE; any other byte (incl. AA, FA, EE, FE) dropped, stay IDLE.
REQ-014 BRK: any byte->IDLE, no push (release event).
REQ-015 EXT: F0->EXT_BRK; 5A->push 4'hB, IDLE; any other byte->IDLE, no push.
REQ-016 EXT_BRK: any byte->IDLE, no push.
REQ-017 Make map: 45->0, 16->1, 1E->2, 26->3, 25->4, 2E->5, 36->6, 3D->7, 3E->8, 46->9, 66->A (backspace), 5A->B (enter), 0D->C (tab).
REQ-018 Push latency: key_valid/fifo_count reflect the entry on the first rising edge after the rx_valid cycle.
REQ-019 key_code driven from registered storage at read pointer; valid whenever key_valid=1.
REQ-020 rd_en with key_valid=1 pops head on that edge; rd_en when empty ignored; no underflow flag.
REQ-021 Push and pop in the same cycle: both occur, count unchanged; legal when full (no overflow) and when empty (push only).
REQ-022 Push when full without pop: event dropped, storage unchanged, overflow set next edge.
REQ-023 ovf_clr clears overflow; a simultaneous new overflow takes priority (overflow stays 1).
REQ-024 Pointers wrap modulo DEPTH; count uses one extra bit to distinguish full from empty.

Reset
REQ-025 rst clears FSM to IDLE, pointers/count to 0, overflow to 0, repeat-filter state to empty; key_valid=0, key_code=4'hF on the next edge.
REQ-026 rst asserted mid-sequence (e.g. after E0 or F0) discards the partial sequence; rst dominates rx_valid, rd_en, ovf_clr.

Configuration
REQ-027 Macro KEY_REPEAT_FILTER_EN: when defined, a register holds the last pushed make value; a make identical to it is dropped until a break (BRK or EXT_BRK completion) for that code clears it; any other make replaces it.
REQ-028 Without KEY_REPEAT_FILTER_EN: every mapped make code pushes (typematic repeats produce repeated entries); no filter register exists.

Structure
REQ-029 Shared package key_pkg holds: scan-code constants (SC_BREAK=F0, SC_EXT=E0, per-key codes), key value constants (KEY_BKSP=A, KEY_ENTER=B, KEY_TAB=C, KEY_NONE=F), parser state enum.
REQ-030 One sub-module: key_sync_fifo (generic DEPTH x 4 storage, pointers, count); parser/map/filter live in key_event_fifo.

Verification
REQ-031 rx bytes 16, F0, 16 -> one entry 1; key_valid=1 one cycle after first strobe; pop -> key_valid=0, key_code=F.
REQ-032 rx E0 5A, then E0 F0 5A, then E0 75 -> exactly one entry B; FSM back in IDLE.
REQ-033 DEPTH=4, five makes 45,16,1E,26,25 without pop -> entries 0,1,2,3; fifo_count=4; overflow=1; ovf_clr -> overflow=0.
REQ-034 Full FIFO, rx make 2E same cycle as rd_en -> head 0 popped, 5 written at tail, count 4, overflow 0.
REQ-035 With KEY_REPEAT_FILTER_EN: 1E,1E,1E,F0 1E,1E -> two entries 2; without macro -> four entries 2.
REQ-036 rx E0 then rst, then 45 -> single entry 0; FSM IDLE, overflow 0.
